// File: rtl/mem1_stage.sv
// Yarc MEM1: issues data-bus req/gnt accesses with byte enables and lane-replicated store data, and registers MEM1/MEM2.
// Latency: the request is combinational from EX/MEM; the MEM1/MEM2 registers load one edge later.
// Backpressure: stall_o while the bus withholds grant, with bubbles inserted meanwhile; stall_i holds everything.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   alu_result_i/alu_oper2_i  effective address (or rd value) and store data
//   mem_oper_i, trap_i        memory operation and trap from earlier stages
//   csr_*_i, is_csr_i         CSR write info, passed through
//   pc_i, instr_valid_i,
//   write_rd_i, rd_addr_i     instruction bookkeeping, passed through
//   stall_i, flush_i          hazard-unit hold and pipeline flush
//   dmem_*                    data bus request channel (req/gnt)
//   stall_o                   stall request while waiting for grant
//   *_o (remaining)           MEM1/MEM2 pipeline registers

package yarc_pkg;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW
  } mem_oper_t;

  typedef enum logic [3:0] {
    INSTR_ADDR_MISALIGNED = 4'd0,
    ILLEGAL_INSTR         = 4'd2,
    BREAKPOINT            = 4'd3,
    LOAD_ADDR_MISALIGNED  = 4'd4,
    STORE_ADDR_MISALIGNED = 4'd6,
    ECALL_M               = 4'd11,
    NO_TRAP               = 4'd15
  } exc_t;

  typedef struct packed {
    logic [31:0] alu_result;
    mem_oper_t   mem_oper;
    logic [1:0]  addr_lsb;
    logic [31:0] csr_wdata;
    logic [11:0] csr_waddr;
    logic        csr_we;
    logic        is_csr;
    exc_t        trap;
    logic [31:0] pc;
    logic        instr_valid;
    logic        write_rd;
    logic [4:0]  rd_addr;
  } mem2_regs_t;

endpackage

module mem1_stage
  import yarc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_oper2_i,
  input  mem_oper_t   mem_oper_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [11:0] csr_waddr_i,
  input  logic        csr_we_i,
  input  logic        is_csr_i,
  input  exc_t        trap_i,
  input  logic [31:0] pc_i,
  input  logic        instr_valid_i,
  input  logic        write_rd_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  output logic        stall_o,
  output logic [31:0] alu_result_o,
  output mem_oper_t   mem_oper_o,
  output logic [1:0]  addr_lsb_o,
  output logic [31:0] csr_wdata_o,
  output logic [11:0] csr_waddr_o,
  output logic        csr_we_o,
  output logic        is_csr_o,
  output exc_t        trap_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        write_rd_o,
  output logic [4:0]  rd_addr_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, HOLD} state_t;

  localparam mem2_regs_t BUBBLE = '{
    alu_result: 32'd0, mem_oper: MEM_NOP, addr_lsb: 2'd0,
    csr_wdata: 32'd0, csr_waddr: 12'd0, csr_we: 1'b0, is_csr: 1'b0,
    trap: NO_TRAP, pc: 32'd0, instr_valid: 1'b0, write_rd: 1'b0, rd_addr: 5'd0
  };

  state_t     state_q, state_d;
  mem2_regs_t pipe_q, pipe_d;

  logic [1:0] addr_lsb;
  logic       is_load, is_store, is_byte, is_half, is_word;
  logic       misaligned, pending;
  exc_t       trap_res;
  logic       req, stall;

  assign addr_lsb = alu_result_i[1:0];

  // Operation decode into access size and direction.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (mem_oper_i)
      MEM_LB, MEM_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      MEM_LH, MEM_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MEM_LW:          begin is_load  = 1'b1; is_word = 1'b1; end
      MEM_SB:          begin is_store = 1'b1; is_byte = 1'b1; end
      MEM_SH:          begin is_store = 1'b1; is_half = 1'b1; end
      MEM_SW:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = instr_valid_i & ((is_half & addr_lsb[0]) | (is_word & (addr_lsb != 2'b00)));

  // An older trap wins over a misalignment detected here.
  always_comb begin
    trap_res = NO_TRAP;
    if (trap_i != NO_TRAP)  trap_res = trap_i;
    else if (misaligned)    trap_res = is_store ? STORE_ADDR_MISALIGNED : LOAD_ADDR_MISALIGNED;
  end

  assign pending = instr_valid_i & (is_load | is_store) & (trap_i == NO_TRAP) & ~misaligned & ~flush_i;

  // Byte lanes and replicated store data; loads use the same lanes but drive zero data.
  always_comb begin
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = 32'd0;
    if (is_byte)      dmem_be_o = 4'b0001 << addr_lsb;
    else if (is_half) dmem_be_o = addr_lsb[1] ? 4'b1100 : 4'b0011;
    else if (is_word) dmem_be_o = 4'b1111;
    if (is_store) begin
      if (is_byte)      dmem_wdata_o = {4{alu_oper2_i[7:0]}};
      else if (is_half) dmem_wdata_o = {2{alu_oper2_i[15:0]}};
      else              dmem_wdata_o = alu_oper2_i;
    end
  end

  assign dmem_we_o   = is_store;
  assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

  // Request FSM. EX/MEM is held by stall_o while in WAIT_GNT, so the
  // combinational address/data stay stable until grant. HOLD covers a grant
  // taken while the pipeline is stalled: the access is done and must not be re-issued.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    stall   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          req = pending;
          if (pending) begin
            if (dmem_gnt_i) state_d = stall_i ? HOLD : IDLE;
            else begin
              state_d = WAIT_GNT;
              stall   = 1'b1;
            end
          end
        end
        WAIT_GNT: begin
          req = 1'b1;
          if (dmem_gnt_i) state_d = stall_i ? HOLD : IDLE;
          else            stall   = 1'b1;
        end
        HOLD: begin
          if (!stall_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Gated by reset so an in-flight request is withdrawn the moment reset asserts.
  assign dmem_req_o = rstn_i & req;
  assign stall_o    = rstn_i & stall;

  // MEM1/MEM2 register: flush clears, stall_i holds, a grant wait inserts bubbles.
  always_comb begin
    pipe_d = pipe_q;
    if (flush_i) begin
      pipe_d = BUBBLE;
    end else if (stall_i) begin
      pipe_d = pipe_q;
    end else if (stall) begin
      pipe_d = BUBBLE;
    end else begin
      pipe_d.alu_result  = alu_result_i;
      pipe_d.mem_oper    = mem_oper_i;
      pipe_d.addr_lsb    = addr_lsb;
      pipe_d.csr_wdata   = csr_wdata_i;
      pipe_d.csr_waddr   = csr_waddr_i;
      pipe_d.csr_we      = csr_we_i;
      pipe_d.is_csr      = is_csr_i;
      pipe_d.trap        = trap_res;
      pipe_d.pc          = pc_i;
      pipe_d.instr_valid = instr_valid_i;
      // A misaligned load keeps its op so MEM2 sees the trap, but must not write rd.
      pipe_d.write_rd    = write_rd_i & ~misaligned;
      pipe_d.rd_addr     = rd_addr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pipe_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
    end
  end

  assign alu_result_o  = pipe_q.alu_result;
  assign mem_oper_o    = pipe_q.mem_oper;
  assign addr_lsb_o    = pipe_q.addr_lsb;
  assign csr_wdata_o   = pipe_q.csr_wdata;
  assign csr_waddr_o   = pipe_q.csr_waddr;
  assign csr_we_o      = pipe_q.csr_we;
  assign is_csr_o      = pipe_q.is_csr;
  assign trap_o        = pipe_q.trap;
  assign pc_o          = pipe_q.pc;
  assign instr_valid_o = pipe_q.instr_valid;
  assign write_rd_o    = pipe_q.write_rd;
  assign rd_addr_o     = pipe_q.rd_addr;

endmodule
